// File: rtl/sram_controller.sv
// sram_controller: sequences 32-bit loads/stores as two 16-bit SRAM half-accesses
// and freezes the pipeline via ready until the access completes.
module sram_controller #(
   parameter int          ACCESS_CYCLES = 2,
   parameter logic [31:0] DATA_BASE     = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   input  logic [15:0] sram_dq_in,
   output logic        sram_dq_oe,
   output logic        sram_we_n
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_rd_q, op_rd_d;
   logic [16:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [17:0] sa_q, sa_d;
   logic [15:0] dq_q, dq_d;
   logic        oe_q, oe_d;
   logic        req, last, latch, acc;
   always_comb begin
      req   = rd_en | wr_en;
      last  = cnt_q == 4'(ACCESS_CYCLES - 1);
      latch = state_q == IDLE && req;
      case (state_q)
         IDLE:    state_d = req ? LO : IDLE;
         LO:      state_d = last ? HI : LO;
         HI:      state_d = last ? DONE : HI;
         default: state_d = IDLE;
      endcase
      cnt_d   = (state_q inside {LO, HI} && !last) ? cnt_q + 4'd1 : 4'd0;
      op_rd_d = latch ? rd_en : op_rd_q;
      idx_d   = latch ? 17'((address - DATA_BASE) >> 2) : idx_q;
      wdata_d = latch ? write_data : wdata_q;
      // bus outputs are computed from the next state so they are registered yet aligned with it
      acc  = state_d inside {LO, HI};
      oe_d = acc && !op_rd_d;
      sa_d = acc ? {idx_d, state_d == HI} : 18'd0;
      dq_d = oe_d ? (state_d == HI ? wdata_d[31:16] : wdata_d[15:0]) : 16'd0;
      rdata_d = !(op_rd_q && last) ? rdata_q :
                state_q == LO ? {rdata_q[31:16], sram_dq_in} :
                state_q == HI ? {sram_dq_in, rdata_q[15:0]} : rdata_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_rd_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         sa_q    <= '0;
         dq_q    <= '0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_rd_q <= op_rd_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         sa_q    <= sa_d;
         dq_q    <= dq_d;
         oe_q    <= oe_d;
      end
   end
   assign ready       = state_q == DONE || (state_q == IDLE && !req);
   assign read_data   = rdata_q;
   assign sram_addr   = sa_q;
   assign sram_dq_out = dq_q;
   assign sram_dq_oe  = oe_q;
   assign sram_we_n   = ~oe_q;
endmodule
